// File: rtl/noc_flit_injector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_flit_injector_if : descriptor, payload, credit and flit-write signals   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface noc_flit_injector_if #(
  parameter int FLIT_W = 8,
  parameter int CNT_W  = 4
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [3:0]        pkt_dest;
  logic [3:0]        pkt_len;
  logic              pl_valid;
  logic              pl_ready;
  logic [FLIT_W-1:0] pl_data;
  logic              credit_in;
  logic              wr_en;
  logic [FLIT_W-1:0] flit_out;
  logic [1:0]        flit_type;
  logic [CNT_W-1:0]  credits;
  logic              busy;
  logic              credit_err;

  modport master (
    input  pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, credit_in,
    output pkt_ready, pl_ready, wr_en, flit_out, flit_type, credits, busy, credit_err
  );

  modport slave (
    output pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, credit_in,
    input  pkt_ready, pl_ready, wr_en, flit_out, flit_type, credits, busy, credit_err
  );
endinterface
`default_nettype wire

// File: rtl/noc_flit_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_flit_injector : packet-to-flit transmitter with credit flow control     |
// | Option macro NOC_INJ_CHECKSUM_EN appends an XOR checksum tail flit.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module noc_flit_injector #(
  parameter int FLIT_W    = 8,
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input wire clk,
  input wire rst_n,
  noc_flit_injector_if.master bus
);

  localparam logic [1:0] C_BODY = 2'b00;
  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_TAIL = 2'b10;
`ifndef NOC_INJ_CHECKSUM_EN
  localparam logic [1:0] C_SINGLE = 2'b11;
`endif
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
`ifdef NOC_INJ_CHECKSUM_EN
    S_BODY = 2'd2,
    S_CSUM = 2'd3
`else
    S_BODY = 2'd2
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_dest;
  logic [3:0]        r_len;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [3:0]        w_cnt_inc;
  logic              w_last;
  logic              r_wr_en;
  logic [FLIT_W-1:0] r_flit;
  logic [FLIT_W-1:0] w_flit_nxt;
  logic [1:0]        r_type;
  logic [1:0]        w_type_nxt;
  logic [CNT_W-1:0]  r_credits;
  logic              r_err;
  logic              w_has_cr;
  logic              w_issue;
  logic              w_accept;
  logic              w_pkt_ready;
  logic              w_pl_ready;
`ifdef NOC_INJ_CHECKSUM_EN
  logic [FLIT_W-1:0] r_csum;
  logic [FLIT_W-1:0] w_csum_nxt;
`endif

  assign w_has_cr  = (r_credits != '0);
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_last    = (w_cnt_inc == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_flit_nxt  = r_flit;
    w_type_nxt  = r_type;
    w_cnt_nxt   = r_cnt;
    w_pkt_ready = 1'b0;
    w_pl_ready  = 1'b0;
`ifdef NOC_INJ_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        w_pkt_ready = 1'b1;
        if (bus.pkt_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'd0;
`ifdef NOC_INJ_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_has_cr) begin
          w_issue    = 1'b1;
          w_flit_nxt = FLIT_W'({r_dest, r_len});
`ifdef NOC_INJ_CHECKSUM_EN
          w_type_nxt  = C_HEAD;
          w_state_nxt = (r_len == 4'd0) ? S_CSUM : S_BODY;
`else
          if (r_len == 4'd0) begin
            w_type_nxt  = C_SINGLE;
            w_state_nxt = S_IDLE;
          end else begin
            w_type_nxt  = C_HEAD;
            w_state_nxt = S_BODY;
          end
`endif
        end
      end
      S_BODY: begin
        w_pl_ready = w_has_cr;
        if (bus.pl_valid && w_has_cr) begin
          w_issue    = 1'b1;
          w_flit_nxt = bus.pl_data;
          w_cnt_nxt  = w_cnt_inc;
`ifdef NOC_INJ_CHECKSUM_EN
          w_csum_nxt  = r_csum ^ bus.pl_data;
          w_type_nxt  = C_BODY;
          w_state_nxt = w_last ? S_CSUM : S_BODY;
`else
          w_type_nxt  = w_last ? C_TAIL : C_BODY;
          w_state_nxt = w_last ? S_IDLE : S_BODY;
`endif
        end
      end
`ifdef NOC_INJ_CHECKSUM_EN
      S_CSUM: begin
        if (w_has_cr) begin
          w_issue     = 1'b1;
          w_flit_nxt  = r_csum;
          w_type_nxt  = C_TAIL;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dest    <= 4'd0;
      r_len     <= 4'd0;
      r_cnt     <= 4'd0;
      r_wr_en   <= 1'b0;
      r_flit    <= '0;
      r_type    <= C_BODY;
      r_credits <= C_FULL;
      r_err     <= 1'b0;
`ifdef NOC_INJ_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr_en <= w_issue;
      r_flit  <= w_flit_nxt;
      r_type  <= w_type_nxt;
`ifdef NOC_INJ_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
      if (w_accept) begin
        r_dest <= bus.pkt_dest;
        r_len  <= bus.pkt_len;
      end
      // A returned credit in the same cycle as an issued flit cancels out.
      if (w_issue && !bus.credit_in) begin
        r_credits <= r_credits - C_ONE;
      end else if (!w_issue && bus.credit_in) begin
        if (r_credits == C_FULL) r_err <= 1'b1;
        else                     r_credits <= r_credits + C_ONE;
      end
    end
  end

  assign bus.pkt_ready  = w_pkt_ready;
  assign bus.pl_ready   = w_pl_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.flit_out   = r_flit;
  assign bus.flit_type  = r_type;
  assign bus.credits    = r_credits;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.credit_err = r_err;

endmodule
`default_nettype wire
